// File: rtl/ab_input_conditioner.sv
// ab_input_conditioner: two-channel synchronizer + debouncer feeding the a/b FSM.
// Each channel has a 2-flop synchronizer and a STABLE/PENDING debounce machine.
// The output follows the synchronized input only after DEB_CYCLES consecutive
// enabled edges on which the two differ.
// Optional: define AB_EDGE_OUT_EN to add one-cycle change pulses a_chg/b_chg.
module ab_input_conditioner #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter logic        A_INIT     = 1'b0,
    parameter logic        B_INIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
`ifdef AB_EDGE_OUT_EN
    output logic a_chg,
    output logic b_chg,
`endif
    output logic busy
);

    localparam int unsigned    CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEB_CYCLES - 1);
    localparam logic [1:0]     INIT = {B_INIT, A_INIT};

    typedef enum logic {Stable, Pending} state_e;

    // Index 0 is channel A, index 1 is channel B.
    state_e          state_q [2];
    state_e          state_d [2];
    logic [CW-1:0]   cnt_q   [2];
    logic [CW-1:0]   cnt_d   [2];
    logic [1:0]      s1_q, s2_q;
    logic [1:0]      out_q, out_d;
    logic            busy_q;
    logic [1:0]      chg_q;

    // Per-channel debounce next-state; en=0 freezes state, count and output.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            out_d[ch]   = out_q[ch];
            if (en) begin
                unique case (state_q[ch])
                    Stable: begin
                        if (s2_q[ch] != out_q[ch]) begin
                            // A one-cycle debounce commits immediately.
                            if (DEB_CYCLES == 1) begin
                                out_d[ch] = s2_q[ch];
                            end else begin
                                state_d[ch] = Pending;
                                cnt_d[ch]   = CW'(1);
                            end
                        end
                    end
                    Pending: begin
                        if (s2_q[ch] == out_q[ch]) begin
                            state_d[ch] = Stable;
                            cnt_d[ch]   = '0;
                        end else if (cnt_q[ch] == LAST) begin
                            out_d[ch]   = s2_q[ch];
                            cnt_d[ch]   = '0;
                            state_d[ch] = Stable;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[ch] = Stable;
                        cnt_d[ch]   = '0;
                    end
                endcase
            end
        end
    end

    // Synchronizers run every edge; state, outputs and busy register together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= INIT;
            s2_q   <= INIT;
            out_q  <= INIT;
            busy_q <= 1'b0;
            chg_q  <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= Stable;
                cnt_q[ch]   <= '0;
            end
        end else begin
            s1_q   <= {b_raw, a_raw};
            s2_q   <= s1_q;
            out_q  <= out_d;
            busy_q <= (state_d[0] == Pending) || (state_d[1] == Pending);
            chg_q  <= out_d ^ out_q;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    assign a    = out_q[0];
    assign b    = out_q[1];
    assign busy = busy_q;

`ifdef AB_EDGE_OUT_EN
    assign a_chg = chg_q[0];
    assign b_chg = chg_q[1];
`else
    logic unused_chg;
    assign unused_chg = ^chg_q;
`endif

endmodule
